// File: rtl/shift_unit.sv
// Multi-cycle barrel-free shifter: moves at most STEP bit positions per clock in SLL/SRL/SRA/ROL modes,
// with a Start/Busy/Done handshake so the control unit can stall on long shifts.
module shift_unit #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int STEP    = 4
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic [1:0]         Op,
   input  logic [WIDTH-1:0]   In,
   input  logic [SHAMT_W-1:0] Shamt,
   output logic [WIDTH-1:0]   Out,
   output logic               Busy,
   output logic               Done
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
   typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROL} op_t;

   // One extra bit so STEP == WIDTH is representable in the step comparison.
   localparam logic [SHAMT_W:0] STEP_EXT  = (SHAMT_W+1)'(STEP);
   localparam logic [SHAMT_W:0] WIDTH_EXT = (SHAMT_W+1)'(WIDTH);

   state_t             state;
   op_t                op_q;
   logic [WIDTH-1:0]   w;
   logic [SHAMT_W-1:0] r;

   logic [SHAMT_W-1:0] step_amt;
   logic [SHAMT_W:0]   back_amt;
   logic [SHAMT_W-1:0] r_next;
   logic [WIDTH-1:0]   w_next;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      step_amt = r;
      w_next   = w;
      if ({1'b0, r} > STEP_EXT)
         step_amt = STEP_EXT[SHAMT_W-1:0];
      back_amt = WIDTH_EXT - {1'b0, step_amt};
      r_next   = r - step_amt;
      case (op_q)
         OP_SLL:  w_next = w << step_amt;
         OP_SRL:  w_next = w >> step_amt;
         OP_SRA:  w_next = $signed(w) >>> step_amt;
         OP_ROL:  w_next = (w << step_amt) | (w >> back_amt);
         default: w_next = w;
      endcase
   end

   // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= S_IDLE;
         op_q  <= OP_SLL;
         w     <= '0;
         r     <= '0;
         Out   <= '0;
         Busy  <= 1'b0;
         Done  <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (Start) begin
                  w    <= In;
                  r    <= Shamt;
                  op_q <= op_t'(Op);
                  if (Shamt == '0) begin
                     Out   <= In;
                     state <= S_DONE;
                     Busy  <= 1'b0;
                     Done  <= 1'b1;
                  end else begin
                     state <= S_SHIFT;
                     Busy  <= 1'b1;
                     Done  <= 1'b0;
                  end
               end else begin
                  state <= S_IDLE;
                  Busy  <= 1'b0;
                  Done  <= 1'b0;
               end
            end
            S_SHIFT: begin
               // Start is deliberately not looked at here: a request during a shift is dropped.
               w <= w_next;
               r <= r_next;
               if (r_next == '0) begin
                  Out   <= w_next;
                  state <= S_DONE;
                  Busy  <= 1'b0;
                  Done  <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               Busy  <= 1'b0;
               Done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit at default parameters: results, latency, Busy/Done handshake,
// ignored Start during a shift, back-to-back starts and reset abort.
module tb_shift_unit;

   localparam logic [1:0] SLL = 2'b00;
   localparam logic [1:0] SRL = 2'b01;
   localparam logic [1:0] SRA = 2'b10;
   localparam logic [1:0] ROL = 2'b11;

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic [1:0]  Op;
   logic [31:0] In;
   logic [4:0]  Shamt;
   logic [31:0] Out;
   logic        Busy;
   logic        Done;

   int tests = 0;
   int fails = 0;
   logic [31:0] prev_out;

   shift_unit dut (
      .Clk   (Clk),
      .Reset (Reset),
      .Start (Start),
      .Op    (Op),
      .In    (In),
      .Shamt (Shamt),
      .Out   (Out),
      .Busy  (Busy),
      .Done  (Done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] din,
                                             input logic [4:0] n);
      case (op)
         SLL:     ref_model = din << n;
         SRL:     ref_model = din >> n;
         SRA:     ref_model = $signed(din) >>> n;
         default: ref_model = (n == 5'd0) ? din : ((din << n) | (din >> (32 - n)));
      endcase
   endfunction

   // Called at a negedge; returns at the negedge where Done is seen. poke=k raises a junk Start before E_k.
   task automatic run(input logic [1:0] op, input logic [31:0] din, input logic [4:0] n,
                      input logic [31:0] exp, input int exp_lat, input int poke, input string tag);
      int lat;
      lat   = 0;
      Start = 1'b1;
      Op    = op;
      In    = din;
      Shamt = n;
      @(posedge Clk);
      @(negedge Clk);
      Op    = 2'($urandom);
      In    = $urandom;
      Shamt = 5'($urandom);
      while (!Done && lat < 20) begin
         check({tag, " busy"}, {31'd0, Busy}, 32'd1);
         check({tag, " hold"}, Out, prev_out);
         if (lat == poke - 1) begin
            Start = 1'b1;
            Op    = SLL;
            In    = 32'hFFFF_FFFF;
            Shamt = 5'd1;
         end else begin
            Start = 1'b0;
         end
         @(posedge Clk);
         @(negedge Clk);
         lat++;
      end
      Start = 1'b0;
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " out"}, Out, exp);
      check({tag, " done"}, {31'd0, Done}, 32'd1);
      check({tag, " busy_at_done"}, {31'd0, Busy}, 32'd0);
      prev_out = exp;
   endtask

   task automatic idle(input int k);
      Start = 1'b0;
      repeat (k) begin
         @(posedge Clk);
         @(negedge Clk);
      end
   endtask

   initial begin
      logic [1:0]  rop;
      logic [31:0] rin;
      logic [4:0]  rn;

      // Reset held two cycles with a zero-shift Start pending: reset must win.
      Reset = 1'b1;
      Start = 1'b1;
      Op    = SLL;
      In    = 32'hDEAD_BEEF;
      Shamt = 5'd0;
      prev_out = 32'd0;
      repeat (2) begin
         @(posedge Clk);
         @(negedge Clk);
         check("reset out", Out, 32'd0);
         check("reset busy", {31'd0, Busy}, 32'd0);
         check("reset done", {31'd0, Done}, 32'd0);
      end
      Reset = 1'b0;
      Start = 1'b0;
      idle(1);
      check("post-reset done", {31'd0, Done}, 32'd0);
      check("post-reset out", Out, 32'd0);

      // Legacy shift-left-by-2 equivalence.
      run(SLL, 32'h0000_0001, 5'd2, 32'h0000_0004, 1, 0, "sll1x2");
      idle(1);
      run(SLL, 32'h3FFF_FFFF, 5'd2, 32'hFFFF_FFFC, 1, 0, "sll3fx2");
      idle(2);

      // Maximum shift in each mode: 8 cycles.
      run(SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 8, 0, "sra31");
      idle(1);
      run(SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 8, 0, "srl31");
      idle(1);
      run(SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 8, 0, "sll31");
      idle(1);

      // Rotate and partial final step.
      run(ROL, 32'h8000_0001, 5'd4, 32'h0000_0018, 1, 0, "rol4");
      idle(1);
      run(ROL, 32'hF000_0000, 5'd9, 32'h0000_01E0, 3, 0, "rol9");
      idle(1);
      run(SRA, 32'h7FFF_FFF0, 5'd5, 32'h03FF_FFFF, 2, 0, "sra5pos");
      idle(1);
      run(ROL, 32'h1234_5678, 5'd0, 32'h1234_5678, 0, 0, "rol0");
      idle(1);

      // Start pulsed at E3 of SRL by 20 is ignored; result after E5.
      run(SRL, 32'hABCD_0000, 5'd20, 32'h0000_0ABC, 5, 3, "srl20poke");
      idle(1);
      check("poke not queued", {31'd0, Busy | Done}, 32'd0);

      // Back-to-back: Start in the DONE cycle, then a zero shift keeps Done high.
      run(SLL, 32'h0000_00FF, 5'd8, 32'h0000_FF00, 2, 0, "b2b_a");
      run(SRL, 32'h0000_FF00, 5'd4, 32'h0000_0FF0, 1, 0, "b2b_b");
      run(SLL, 32'hCAFE_F00D, 5'd0, 32'hCAFE_F00D, 0, 0, "b2b_zero");
      run(SRA, 32'h8000_0010, 5'd4, 32'hF800_0001, 1, 0, "b2b_c");
      idle(1);

      // Reset at E2 of a 31-bit shift aborts it.
      Start = 1'b1;
      Op    = SRL;
      In    = 32'hFFFF_FFFF;
      Shamt = 5'd31;
      @(posedge Clk);
      @(negedge Clk);
      Start = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      check("abort out", Out, 32'd0);
      check("abort busy", {31'd0, Busy}, 32'd0);
      check("abort done", {31'd0, Done}, 32'd0);
      prev_out = 32'd0;
      begin
         int seen;
         seen = 0;
         repeat (10) begin
            @(posedge Clk);
            @(negedge Clk);
            if (Done) seen++;
         end
         check("abort no done", 32'(seen), 32'd0);
      end

      // Short random sweep against the single-cycle reference.
      for (int i = 0; i < 30; i++) begin
         rop = 2'($urandom);
         rin = $urandom;
         rn  = 5'($urandom);
         run(rop, rin, rn, ref_model(rop, rin, rn), (int'(rn) + 3) / 4, 0, "rand");
         idle(int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/shift_unit.md
# shift_unit

Parametrised multi-cycle shifter for the CPU datapath, the successor to the fixed shift-left-by-2 block. It shifts a WIDTH-bit operand by a run-time amount in one of four modes: logical left, logical right, arithmetic right, and rotate left. It moves at most STEP bit positions per clock, which trades latency for area. A Start/Busy/Done handshake lets the control unit stall while a shift is in progress.

## Interface
Parameters:
- WIDTH, 32, operand and result width; WIDTH == 2**SHAMT_W is required.
- SHAMT_W, 5, width of the shift-amount port.
- STEP, 4, maximum bit positions shifted per cycle; 1 <= STEP <= WIDTH.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled only in IDLE or DONE.
- Op  in  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- In  in  WIDTH  operand; captured with Start.
- Shamt  in  SHAMT_W  shift amount n, range 0..WIDTH-1; captured with Start.
- Out  out  WIDTH  last completed result; holds until the next completion.
- Busy  out  1  high while a shift is in progress.
- Done  out  1  one-cycle pulse when Out has been updated.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Internal registers: working register W (WIDTH bits), remaining count R (SHAMT_W bits), latched Op.
- IDLE or DONE with Start=1:
  - Latch In into W, Shamt into R, and Op.
  - If Shamt==0, go to DONE and load Out=In.
  - Otherwise go to SHIFT.
- IDLE or DONE with Start=0: DONE returns to IDLE; IDLE stays.
- SHIFT, each cycle:
  - s = min(R, STEP); R <= R - s.
  - W is shifted by s according to Op:
    - SLL: zero fill at the LSB.
    - SRL: zero fill at the MSB.
    - SRA: fill with W[WIDTH-1], which equals the original In MSB.
    - ROL: bits leaving the MSB re-enter at the LSB.
  - When R - s == 0, load Out with the shifted W and go to DONE.
- Start while in SHIFT is ignored; the in-flight shift is unaffected and the request is not queued.
- In, Shamt, and Op changes after capture do not affect the in-flight shift.
- Outputs by state:
  - Busy = 1 only in SHIFT.
  - Done = 1 only in DONE.
  - Busy and Done are never high together.
- Result must equal the single-cycle reference: In<<n, In>>n, $signed(In)>>>n, or (In<<n)|(In>>(WIDTH-n)), with the rotate's n=0 case giving In.

## Timing
- Reset (synchronous, at the rising edge with Reset=1):
  - state=IDLE, Out=0, Busy=0, Done=0, W=0, R=0.
  - Reset overrides Start in the same cycle.
- Reset mid-operation: the shift is aborted, no Done is produced, and Out is cleared to 0.
- Latency: Start sampled at edge E0 with amount n; c = ceil(n/STEP).
  - Done and the new Out are visible after edge E_c; for n=0 that is after E0.
  - Busy is high for exactly c cycles, after E0 through E_(c-1).
  - n=0 never asserts Busy.
- Maximum latency: ceil((WIDTH-1)/STEP); 8 cycles at the default parameters.
- Back-to-back: Start asserted while Done=1 is accepted. The next operation begins with no idle cycle, and Done drops after that edge unless n=0, in which case Done stays high for another cycle with the new Out.
- Out changes only at the edge that enters DONE, or at reset.

## Test plan
- Reset: assert Reset for 2 cycles with Start=1 → Out=0x00000000, Busy=0, Done=0; no Done follows.
- Legacy equivalence: SLL, In=0x00000001, Shamt=2 → Out=0x00000004 and Done after E1, with Busy high for 1 cycle. Also In=0x3FFFFFFF, Shamt=2 → 0xFFFFFFFC.
- Modes at Shamt=31 (8 cycles each):
  - SRA, In=0x80000000 → 0xFFFFFFFF.
  - SRL, same In → 0x00000001.
  - SLL, In=0x00000001 → 0x80000000.
- Rotate and zero shift:
  - ROL, In=0x80000001, Shamt=4 → 0x00000018 after E1.
  - ROL, In=0x12345678, Shamt=0 → 0x12345678 after E0, Busy never high.
- Handshake boundaries:
  - Pulse Start at E3 of an SRL by 20 → ignored; the result is unchanged and appears after E5.
  - Start in the DONE cycle → accepted back-to-back.
  - Reset at E2 of a 31-bit shift → no Done, Out=0.
- Random regression: 10,000 random In/Op/Shamt with random Start gaps, at STEP = 1, 4, and 32 → every Done matches the reference model and latency equals ceil(n/STEP).
